// File: rtl/mem_load_queue.sv
// In-order MEM-stage load queue: tracks in-flight data-sram requests, matches
// in-order responses to the oldest waiting entry, and extracts load results.
module mem_load_queue #(
  parameter int unsigned DEPTH    = 2,
  parameter int unsigned DATA_WD  = 32,
  parameter int unsigned LD_OP_WD = 5
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic                in_req,
  input  logic [LD_OP_WD-1:0] in_ld_op,
  input  logic [1:0]          in_offset,
  input  logic [DATA_WD-1:0]  in_result,
  input  logic                flush,
  input  logic                data_sram_data_ok,
  input  logic [DATA_WD-1:0]  data_sram_rdata,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [DATA_WD-1:0]  out_data
);

  localparam int unsigned PTR_WD = $clog2(DEPTH);
  localparam int unsigned CNT_WD = $clog2(DEPTH + 1);
  localparam int unsigned SUM_WD = CNT_WD + 2;

  logic [DEPTH-1:0]    r_req;
  logic [DEPTH-1:0]    r_data_vld;
  logic [LD_OP_WD-1:0] r_ld_op  [DEPTH];
  logic [1:0]          r_offset [DEPTH];
  logic [DATA_WD-1:0]  r_result [DEPTH];
  logic [DATA_WD-1:0]  r_data   [DEPTH];
  logic [PTR_WD-1:0]   r_head;
  logic [PTR_WD-1:0]   r_tail;
  logic [CNT_WD-1:0]   r_count;
  logic [CNT_WD-1:0]   r_discard;

  logic [CNT_WD-1:0]   w_pending;
  logic                w_has_wait;
  logic [PTR_WD-1:0]   w_wait_idx;
  logic [PTR_WD-1:0]   w_idx;
  logic                w_head_wait;
  logic                w_resp;
  logic                w_bypass;
  logic                w_head_done;
  logic                w_push;
  logic                w_pop;
  logic                w_store;
  logic [DATA_WD-1:0]  w_src;
  logic [1:0]          w_off;
  logic [LD_OP_WD-1:0] w_op;
  logic [7:0]          w_byte;
  logic [15:0]         w_half;
  logic [DATA_WD-1:0]  w_load;
  logic [SUM_WD-1:0]   w_disc_sum;
  logic [SUM_WD-1:0]   w_disc_flush;

  // Scan live entries from head: count waiting ones and find the oldest.
  always_comb begin
    w_pending  = '0;
    w_has_wait = 1'b0;
    w_wait_idx = r_head;
    w_idx      = r_head;
    for (int k = 0; k < DEPTH; k++) begin
      w_idx = r_head + PTR_WD'(k);
      if ((CNT_WD'(k) < r_count) && r_req[w_idx] && !r_data_vld[w_idx]) begin
        w_pending = w_pending + 1'b1;
        if (!w_has_wait) begin
          w_has_wait = 1'b1;
          w_wait_idx = w_idx;
        end
      end
    end
  end

  assign w_head_wait = (r_count != '0) && r_req[r_head] && !r_data_vld[r_head];
  assign w_resp      = data_sram_data_ok && (r_discard == '0) && w_has_wait;
  assign w_bypass    = w_resp && w_head_wait;
  assign w_head_done = !r_req[r_head] || r_data_vld[r_head] || w_bypass;

  assign in_ready  = r_count < CNT_WD'(DEPTH);
  assign out_valid = (r_count != '0) && w_head_done && !flush;
  assign w_push    = in_valid && in_ready && !flush;
  assign w_pop     = out_valid && out_ready;
  // A bypassed response whose entry leaves this cycle is never stored.
  assign w_store   = w_resp && !(w_bypass && w_pop);

  assign w_src  = w_bypass ? data_sram_rdata : r_data[r_head];
  assign w_off  = r_offset[r_head];
  assign w_op   = r_ld_op[r_head];
  assign w_byte = w_src[{w_off, 3'b000} +: 8];
  assign w_half = w_off[1] ? w_src[31:16] : w_src[15:0];

  always_comb begin
    w_load = w_src;
    if (w_op[0])      w_load = {{(DATA_WD-8){w_byte[7]}}, w_byte};
    else if (w_op[3]) w_load = {{(DATA_WD-8){1'b0}}, w_byte};
    else if (w_op[1]) w_load = {{(DATA_WD-16){w_half[15]}}, w_half};
    else if (w_op[4]) w_load = {{(DATA_WD-16){1'b0}}, w_half};
  end

  assign out_data = (r_req[r_head] && |w_op) ? w_load : r_result[r_head];

  // Responses still owed after a flush: old debt, waiting entries, and the
  // request accepted alongside the flush, minus any response landing now.
  assign w_disc_sum   = SUM_WD'(r_discard) + SUM_WD'(w_pending)
                      + SUM_WD'(in_valid && in_req);
  assign w_disc_flush = (data_sram_data_ok && (w_disc_sum != '0))
                      ? w_disc_sum - 1'b1 : w_disc_sum;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_head     <= '0;
      r_tail     <= '0;
      r_count    <= '0;
      r_discard  <= '0;
      r_data_vld <= '0;
    end else if (flush) begin
      r_count    <= '0;
      r_tail     <= r_head;
      r_data_vld <= '0;
      r_discard  <= CNT_WD'(w_disc_flush);
    end else begin
      if (w_push) begin
        r_req[r_tail]      <= in_req;
        r_ld_op[r_tail]    <= in_ld_op;
        r_offset[r_tail]   <= in_offset;
        r_result[r_tail]   <= in_result;
        r_data_vld[r_tail] <= 1'b0;
        r_tail             <= r_tail + 1'b1;
      end
      if (w_store) begin
        r_data[w_wait_idx]     <= data_sram_rdata;
        r_data_vld[w_wait_idx] <= 1'b1;
      end
      if (w_pop) r_head <= r_head + 1'b1;
      r_count <= r_count + CNT_WD'(w_push) - CNT_WD'(w_pop);
      if (data_sram_data_ok && (r_discard != '0)) r_discard <= r_discard - 1'b1;
    end
  end

  // A response with nothing owed and nothing waiting is a protocol error.
  always_ff @(posedge clk) begin
    if (!reset) assert (!(data_sram_data_ok && (r_discard == '0) && !w_has_wait));
  end

endmodule

// File: doc/mem_load_queue.md
MEM_LOAD_QUEUE -- requirements
Module: mem_load_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 2, meaning the number of in-flight MEM entries (power of 2, >=2).
REQ-002 SHALL have parameter DATA_WD, default 32, meaning the data and result width.
REQ-003 SHALL have parameter LD_OP_WD, default 5, meaning the one-hot load-op width: bit0 ld.b, bit1 ld.h, bit2 ld.w, bit3 ld.bu, bit4 ld.hu.
REQ-004 SHALL use one clock; reset is synchronous and active-high.
REQ-005 clk  in  1  clock; all state updates on the rising edge.
REQ-006 reset  in  1  synchronous active-high reset.
REQ-007 in_valid  in  1  EX offers an instruction.
REQ-008 in_ready  out  1  queue accepts this cycle.
REQ-009 in_req  in  1  the instruction's data-sram request has already been accepted (addr_ok done).
REQ-010 in_ld_op  in  LD_OP_WD  one-hot load op; all-zero means not a load.
REQ-011 in_offset  in  2  address bits [1:0].
REQ-012 in_result  in  DATA_WD  ALU/forwarded result.
REQ-013 flush  in  1  exception/ertn taken; cancels all entries.
REQ-014 data_sram_data_ok  in  1  one in-order response.
REQ-015 data_sram_rdata  in  DATA_WD  response word.
REQ-016 out_valid  out  1  head entry complete.
REQ-017 out_ready  in  1  WB accepts.
REQ-018 out_data  out  DATA_WD  final result.

Function
REQ-019 SHALL hold a circular FIFO of DEPTH entries {req, ld_op, offset, result, data, data_vld}, with head/tail pointers of clog2(DEPTH) bits that wrap modulo DEPTH, and a count of clog2(DEPTH+1) bits.
REQ-020 in_ready SHALL be (count < DEPTH) and SHALL NOT depend combinationally on out_ready or data_sram_data_ok.
REQ-021 Push SHALL occur when in_valid && in_ready && !flush; the entry is written at tail with data_vld=0.
REQ-022 SHALL track pending = the number of entries with req && !data_vld, plus discard, a count of clog2(DEPTH+1) bits of responses still owed to flushed requests.
REQ-023 On data_sram_data_ok with discard>0, discard SHALL decrement and the data SHALL be dropped.
REQ-024 On data_sram_data_ok with discard==0, the data SHALL be written to the oldest entry with req && !data_vld and that entry's data_vld SHALL be set.
REQ-025 The head SHALL be complete when !req, or data_vld, or (data_ok && discard==0 && head is awaiting data), giving same-cycle bypass.
REQ-026 out_valid SHALL equal count>0 && head complete; pop SHALL occur on out_valid && out_ready; push and pop SHALL be allowed in the same cycle (count unchanged).
REQ-027 out_data SHALL be the extracted load when req && |ld_op, else result.
REQ-028 The data source for extraction SHALL be the live rdata when bypassing, else the stored data.
REQ-029 Extraction, ld.b/ld.bu: select byte offset*8 and sign-/zero-extend.
REQ-030 Extraction, ld.h/ld.hu: select halfword offset[1]*16 (offset[0] ignored) and sign-/zero-extend.
REQ-031 Extraction, ld.w: pass the full word.
REQ-032 On flush, all entries SHALL be invalidated (count=0, head=tail) and discard SHALL become discard + pending + (in_valid && in_req) - (data_ok ? 1 : 0); out_valid SHALL be masked low that cycle.
REQ-033 flush together with in_valid: the incoming entry SHALL NOT be pushed, but its accepted request SHALL be counted into discard.
REQ-034 data_ok with pending==0 and discard==0 is a protocol error: state SHALL be unchanged and the simulation assertion SHALL fire.
REQ-035 A response SHALL never be written to an entry popped in the same cycle other than via the bypass.

Reset
REQ-036 On reset: count=0, head=tail=0, discard=0, all data_vld=0, out_valid=0, in_ready=1; out_data is don't-care.
REQ-037 Reset SHALL dominate flush, push, pop and data_ok in the same cycle; responses outstanding at reset are the system's responsibility.

Verification
REQ-038 ld.b, offset 3, rdata 0x80FF_1234, data_ok in the same cycle, out_ready=1 -> out_valid the same cycle, out_data 0xFFFF_FF80.
REQ-039 Two loads pushed (ld.hu offset 2, ld.w); out_ready=0; rdata 0xABCD_0001 then 0x5555_AAAA -> in_ready=0; after out_ready=1, outputs 0x0000_ABCD then 0x5555_AAAA.
REQ-040 Non-load, in_result 0x1234, no req -> out_valid the cycle after push, out_data 0x1234, no data_ok needed.
REQ-041 Two requests outstanding, flush, then 2 data_ok, then a new ld.w with rdata 0xDEAD_BEEF -> first two responses dropped (discard 2->0), out_data 0xDEAD_BEEF.
REQ-042 Flush coincident with data_ok and in_valid&&in_req while pending=1 -> discard becomes 1 and count becomes 0.
REQ-043 DEPTH=4: 9 pushes/pops with random out_ready stalls -> pointers wrap, in-order results, count never exceeds 4.
